// File: rtl/dsp_mac_sequencer_pkg.sv
// dsp_pkg: opmode encodings, slice latency and FSM state type shared by the MAC sequencer.
package dsp_pkg;
  localparam logic [7:0] OPMODE_MUL_ONLY = 8'h01;
  localparam logic [7:0] OPMODE_MUL_ACC  = 8'h09;
  localparam int DSP_LAT = 3;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/dsp_mac_sequencer_pipe_tracker.sv
// dsp_pipe_tracker: shadows the slice A1->M->P pipeline with {valid, first} tags to time the enables.
module dsp_pipe_tracker #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_issue,
  input  logic i_first,
  output logic o_ce_ab,
  output logic o_ce_m,
  output logic o_ce_p,
  output logic o_first_at_m,
  output logic o_last_done
);
  logic [DEPTH-1:0] r_v;
  logic [DEPTH-2:0] r_f;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_v <= '0;
      r_f <= '0;
    end else begin
      r_v <= DEPTH'({r_v, i_issue});
      r_f <= (DEPTH-1)'({r_f, i_first & i_issue});
    end
  assign o_ce_ab      = r_v[0];
  assign o_ce_m       = r_v[DEPTH-2];
  assign o_ce_p       = r_v[DEPTH-1];
  assign o_first_at_m = r_v[DEPTH-2] & r_f[DEPTH-2];
  // P updates at the coming edge and nothing younger is in flight
  assign o_last_done  = r_v[DEPTH-1] & ~|r_v[DEPTH-2:0];
endmodule

// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: streams N operand pairs into a DSP48A1 and returns the accumulated P.
module dsp_mac_sequencer import dsp_pkg::*; #(
  parameter int LEN_W   = 8,
  parameter int DSP_LAT = dsp_pkg::DSP_LAT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [17:0]      in_a,
  input  logic [17:0]      in_b,
  output logic [17:0]      dsp_A,
  output logic [17:0]      dsp_B,
  output logic [47:0]      dsp_C,
  output logic [17:0]      dsp_D,
  output logic             dsp_CARRYIN,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_CEA,
  output logic             dsp_CEB,
  output logic             dsp_CEM,
  output logic             dsp_CEP,
  output logic             dsp_CEOPMODE,
  input  logic [47:0]      dsp_P,
  input  logic             dsp_CARRYOUT,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [47:0]      res_p,
  output logic             res_carry
);
  state_t           r_state;
  logic [LEN_W-1:0] r_cnt;
  logic             r_first;
  logic             r_zero;
  logic [17:0]      r_a;
  logic [17:0]      r_b;
  logic             w_acc;
  logic             w_ce_ab;
  logic             w_first_m;
  logic             w_last_done;
  assign w_acc = in_valid & in_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_first <= 1'b0;
      r_zero  <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
    end else begin
      if (w_acc) begin
        r_a <= in_a;
        r_b <= in_b;
      end
      case (r_state)
        IDLE: if (start) begin
          r_cnt   <= len;
          r_first <= 1'b1;
          r_zero  <= (len == '0);
          r_state <= (len == '0) ? DONE : RUN;
        end
        RUN: if (w_acc) begin
          r_cnt   <= r_cnt - LEN_W'(1);
          r_first <= 1'b0;
          if (r_cnt == LEN_W'(1)) r_state <= DRAIN;
        end
        DRAIN: if (w_last_done) r_state <= DONE;
        DONE: if (res_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  dsp_pipe_tracker #(.DEPTH(DSP_LAT)) u_track (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_issue      (w_acc),
    .i_first      (r_first),
    .o_ce_ab      (w_ce_ab),
    .o_ce_m       (dsp_CEM),
    .o_ce_p       (dsp_CEP),
    .o_first_at_m (w_first_m),
    .o_last_done  (w_last_done)
  );
  assign busy         = r_state != IDLE;
  assign in_ready     = r_state == RUN;
  assign dsp_A        = r_a;
  assign dsp_B        = r_b;
  assign dsp_C        = '0;
  assign dsp_D        = '0;
  assign dsp_CARRYIN  = 1'b0;
  assign dsp_CEA      = w_ce_ab;
  assign dsp_CEB      = w_ce_ab;
  assign dsp_CEOPMODE = 1'b1;
  // Z=0 on the first product discards whatever P held from an earlier job
  assign dsp_opmode   = w_first_m ? OPMODE_MUL_ONLY : OPMODE_MUL_ACC;
  assign res_valid    = r_state == DONE;
  assign res_p        = (res_valid && !r_zero) ? dsp_P : '0;
  assign res_carry    = res_valid && !r_zero && dsp_CARRYOUT;
endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// tb_dsp_mac_sequencer: directed jobs against a behavioural DSP48A1 load, scoreboarded results.
module tb_dsp_mac_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [7:0] len = '0;
  logic busy, in_ready, res_valid, res_carry;
  logic in_valid = 1'b0;
  logic res_ready = 1'b0;
  logic [17:0] in_a = '0, in_b = '0;
  logic [17:0] dsp_A, dsp_B, dsp_D;
  logic [47:0] dsp_C, res_p;
  logic dsp_CARRYIN, dsp_CEA, dsp_CEB, dsp_CEM, dsp_CEP, dsp_CEOPMODE;
  logic [7:0] dsp_opmode;
  logic [47:0] dsp_P;
  logic dsp_CARRYOUT;
  always #5 clk = ~clk;
  dsp_mac_sequencer #(.LEN_W(8), .DSP_LAT(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .dsp_A(dsp_A), .dsp_B(dsp_B), .dsp_C(dsp_C), .dsp_D(dsp_D), .dsp_CARRYIN(dsp_CARRYIN),
    .dsp_opmode(dsp_opmode), .dsp_CEA(dsp_CEA), .dsp_CEB(dsp_CEB), .dsp_CEM(dsp_CEM),
    .dsp_CEP(dsp_CEP), .dsp_CEOPMODE(dsp_CEOPMODE), .dsp_P(dsp_P), .dsp_CARRYOUT(dsp_CARRYOUT),
    .res_valid(res_valid), .res_ready(res_ready), .res_p(res_p), .res_carry(res_carry)
  );
  // Behavioural DSP48A1 load: A1/B1 -> M -> P, opmode registered, never reset (starts stale)
  logic [17:0] m_a1 = 18'h3ABCD, m_b1 = 18'h12345;
  logic signed [35:0] m_m = 36'sh123456789;
  logic [7:0] m_op = 8'h09;
  logic [47:0] m_p = 48'hDEAD_BEEF_0123;
  logic m_co = 1'b0;
  logic [47:0] w_z, w_mx;
  assign w_z  = (m_op[3:2] == 2'b10) ? m_p : 48'd0;
  assign w_mx = 48'(m_m);
  assign dsp_P = m_p;
  assign dsp_CARRYOUT = m_co;
  int cyc = 0, n_cea = 0, n_cem = 0, n_cep = 0, n_first = 0;
  always @(posedge clk) begin
    if (dsp_CEA) m_a1 <= dsp_A;
    if (dsp_CEB) m_b1 <= dsp_B;
    if (dsp_CEM) m_m <= 36'($signed(m_a1)) * 36'($signed(m_b1));
    if (dsp_CEOPMODE) m_op <= dsp_opmode;
    if (dsp_CEP) {m_co, m_p} <= {1'b0, w_z} + {1'b0, w_mx};
    cyc <= cyc + 1;
    n_cea <= n_cea + int'(dsp_CEA);
    n_cem <= n_cem + int'(dsp_CEM);
    n_cep <= n_cep + int'(dsp_CEP);
    n_first <= n_first + int'(dsp_CEM && dsp_opmode == 8'h01);
  end
  int n_tests = 0, n_fail = 0;
  logic [47:0] sb[$];
  logic [17:0] ja[8], jb[8];
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send_job(input int n, input bit bub, output int acc);
    logic [47:0] sum = '0;
    int i = 0, g = 0;
    for (int k = 0; k < n; k++) sum += 48'(ja[k]) * 48'(jb[k]);
    @(negedge clk);
    start = 1'b1;
    len = 8'(n);
    sb.push_back(sum);
    @(negedge clk);
    start = 1'b0;
    acc = cyc;
    while (i < n && g < 100) begin
      in_valid = !(bub && g[0]);
      in_a = ja[i];
      in_b = jb[i];
      if (in_valid && in_ready) begin
        i++;
        acc = cyc + 1;
      end
      @(negedge clk);
      g++;
    end
    in_valid = 1'b0;
    check("pairs_accepted", 64'(i), 64'(n));
  endtask
  task automatic get_result(input string tag, input int acc, input int lat, input int hold);
    logic [47:0] exp;
    int k = 0;
    while (!res_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_res_valid"}, 64'(res_valid), 64'd1);
    if (lat >= 0) check({tag, "_latency"}, 64'(cyc - acc), 64'(lat));
    exp = (sb.size() != 0) ? sb.pop_front() : 48'hBAD0_BAD0_BAD0;
    check({tag, "_res_p"}, 64'(res_p), 64'(exp));
    check({tag, "_res_carry"}, 64'(res_carry), 64'd0);
    for (int h = 0; h < hold; h++) begin
      start = h[0];
      len = 8'd3;
      @(negedge clk);
      check({tag, "_hold_valid"}, 64'(res_valid), 64'd1);
      check({tag, "_hold_p"}, 64'(res_p), 64'(exp));
    end
    start = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, "_idle_after"}, 64'(busy), 64'd0);
  endtask
  initial begin
    int acc, a0, m0, p0, f0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_opmode", 64'(dsp_opmode), 64'h09);
    check("rst_ceopmode", 64'(dsp_CEOPMODE), 64'd1);
    check("rst_ce", 64'({dsp_CEA, dsp_CEB, dsp_CEM, dsp_CEP}), 64'd0);
    check("rst_ab", 64'({dsp_A, dsp_B}), 64'd0);
    rst_n = 1'b1;
    ja[0] = 1; jb[0] = 2; ja[1] = 3; jb[1] = 4; ja[2] = 5; jb[2] = 6; ja[3] = 7; jb[3] = 8;
    f0 = n_first;
    send_job(4, 1'b0, acc);
    get_result("contig", acc, 3, 0);
    check("contig_first_op", 64'(n_first - f0), 64'd1);
    a0 = n_cea; m0 = n_cem; p0 = n_cep; f0 = n_first;
    send_job(4, 1'b1, acc);
    get_result("bubble", acc, 3, 0);
    check("bubble_cea", 64'(n_cea - a0), 64'd4);
    check("bubble_cem", 64'(n_cem - m0), 64'd4);
    check("bubble_cep", 64'(n_cep - p0), 64'd4);
    check("bubble_first_op", 64'(n_first - f0), 64'd1);
    a0 = n_cea; m0 = n_cem; p0 = n_cep;
    send_job(0, 1'b0, acc);
    get_result("zero", acc, 0, 0);
    check("zero_no_ce", 64'((n_cea - a0) + (n_cem - m0) + (n_cep - p0)), 64'd0);
    ja[0] = 10; jb[0] = 10; ja[1] = 1; jb[1] = 1;
    send_job(2, 1'b0, acc);
    get_result("job1", acc, 3, 0);
    ja[0] = 2; jb[0] = 3;
    send_job(1, 1'b0, acc);
    get_result("job2", acc, 3, 0);
    ja[0] = 7; jb[0] = 9;
    send_job(1, 1'b0, acc);
    get_result("stall", acc, 3, 10);
    @(negedge clk);
    check("stall_start_ignored", 64'(busy), 64'd0);
    start = 1'b1;
    len = 8'd5;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    in_a = 18'd3;
    in_b = 18'd3;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    check("abort_busy_before", 64'(busy), 64'd1);
    check("abort_ab_before", 64'(dsp_A), 64'd3);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd0);
    check("abort_ce", 64'({dsp_CEA, dsp_CEB, dsp_CEM, dsp_CEP}), 64'd0);
    check("abort_ab", 64'({dsp_A, dsp_B}), 64'd0);
    check("abort_opmode", 64'({dsp_CEOPMODE, dsp_opmode}), 64'h109);
    @(negedge clk);
    rst_n = 1'b1;
    ja[0] = 4; jb[0] = 5;
    send_job(1, 1'b0, acc);
    get_result("post_rst", acc, 3, 0);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
